regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register-address width.
REQ-003 The block SHALL have parameter NUM_REGS, default 32, meaning number of architectural registers, equal to 2**ADDR_W.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning asynchronous, active-low reset.
REQ-006 The block SHALL have port wr_data, input, DATA_W, meaning write-back data from the memory stage.
REQ-007 The block SHALL have port wr_address, input, ADDR_W, meaning write-back destination register.
REQ-008 The block SHALL have port wr_enable, input, 1, meaning write-back valid.
REQ-009 The block SHALL have port rd1_enable, input, 1, meaning read port 1 active.
REQ-010 The block SHALL have port rd1_address, input, ADDR_W, meaning read port 1 source register.
REQ-011 The block SHALL have port rd1_data, output, DATA_W, meaning read port 1 result, combinational.
REQ-012 The block SHALL have ports rd2_enable, rd2_address and rd2_data, identical in direction, width and meaning to read port 1.

Function
REQ-013 The block SHALL hold NUM_REGS registers of DATA_W bits each.
REQ-014 The block SHALL write wr_data into register wr_address on a rising clk edge when wr_enable=1, wr_address!=0 and rst_n=1.
REQ-015 The block SHALL ignore writes to address 0, so register 0 always reads 0.
REQ-016 The block SHALL make a write visible in storage exactly 1 cycle after the edge on which it is sampled.
REQ-017 Each read port SHALL output 0 when rst_n=0, when its enable=0, or when its address=0, in that priority order.
REQ-018 Each read port SHALL otherwise forward wr_data combinationally (write-through bypass) when wr_enable=1 and wr_address equals its address, and SHALL output the stored register value in all other cases.
REQ-019 Both read ports SHALL operate independently and MAY target the same register, including the register being written, in the same cycle.
REQ-020 Read outputs SHALL have zero-cycle latency: they depend only on current inputs and current storage.
REQ-021 A write with wr_enable=0 SHALL leave storage unchanged regardless of wr_address and wr_data.

Reset
REQ-022 Assertion of rst_n=0 SHALL asynchronously clear all NUM_REGS registers to 0, without waiting for a clk edge.
REQ-023 While rst_n=0, the block SHALL discard writes and drive rd1_data=rd2_data=0.
REQ-024 Reset asserted in the middle of a write cycle SHALL leave that write unperformed; the first write after deassertion SHALL take effect on the first rising clk edge with rst_n=1.

Structure
REQ-025 DATA_W, ADDR_W, NUM_REGS and the zero-register constant REG_ZERO=0 SHALL reside in the shared pipeline defines package used by all stages.
REQ-026 The block SHALL be a single module with no sub-modules; storage, write logic and both read muxes SHALL be contained in it.
REQ-027 The top level SHALL drive wr_data, wr_address and wr_enable from the registered outputs of the memory-to-writeback stage, and SHALL drive the read ports from the decode stage.

Verification
REQ-028 The bench SHALL apply reset, then read all 32 addresses on both ports with enables set to 1, and SHALL check that every read returns 0x00000000.
REQ-029 The bench SHALL write 0xDEADBEEF to r5, and on the following cycle SHALL read r5 on rd1, expecting rd1_data=0xDEADBEEF.
REQ-030 The bench SHALL write 0x12345678 to r0, then read r0, expecting rd1_data=0.
REQ-031 The bench SHALL write 0xCAFEF00D to r7 while rd1_address=rd2_address=7 in the same cycle, expecting both ports to read 0xCAFEF00D before the clk edge.
REQ-032 The bench SHALL write 0x1 to r3, then read r3 with rd2_enable=0, expecting rd2_data=0; with rd2_enable=1, it SHALL expect rd2_data=0x1.
REQ-033 The bench SHALL fill r1 through r31 with nonzero values, pulse rst_n low for 3 ns between clk edges, and SHALL check that all registers read 0 immediately and after deassertion.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared pipeline defines: datapath widths and the hard-wired zero register.
`timescale 1ns/1ps
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int REG_ZERO = 0;

endpackage : regfile_pkg

// File: rtl/regfile_if.sv
// Register-file bus: one write-back port from the memory/write-back stage
// and two read ports from the decode stage.
`timescale 1ns/1ps
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);

  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_address;
  logic              wr_enable;

  logic              rd1_enable;
  logic [ADDR_W-1:0] rd1_address;
  logic [DATA_W-1:0] rd1_data;

  logic              rd2_enable;
  logic [ADDR_W-1:0] rd2_address;
  logic [DATA_W-1:0] rd2_data;

  // Pipeline side: drives write-back and read requests, receives read data.
  modport master (
    output wr_data, wr_address, wr_enable,
    output rd1_enable, rd1_address,
    output rd2_enable, rd2_address,
    input  rd1_data, rd2_data
  );

  // Register-file side.
  modport slave (
    input  wr_data, wr_address, wr_enable,
    input  rd1_enable, rd1_address,
    input  rd2_enable, rd2_address,
    output rd1_data, rd2_data
  );

endinterface : regfile_if

// File: rtl/regfile.sv
// Architectural register file: NUM_REGS x DATA_W storage with r0 hard-wired
// to zero, one write port and two combinational read ports with
// write-through bypass so a value being written is visible in the same cycle.
`timescale 1ns/1ps
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_if.slave    bus
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              wr_fire_s;
  logic [DATA_W-1:0] rd1_data_s;
  logic [DATA_W-1:0] rd2_data_s;

  // Read-port priority: reset, then disabled port, then r0, then bypass of
  // the in-flight write, otherwise the stored value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_active,
    input logic              rd_en,
    input logic [ADDR_W-1:0] rd_addr,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_val,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] result;
    if (rst_active) begin
      result = '0;
    end else if (!rd_en) begin
      result = '0;
    end else if (rd_addr == ZERO_ADDR) begin
      result = '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      result = wr_val;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  assign wr_fire_s = bus.wr_enable && (bus.wr_address != ZERO_ADDR);

  // Storage update: asynchronous clear, writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_fire_s) begin
      regs_r[bus.wr_address] <= bus.wr_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Combinational read muxes for both ports, evaluated independently.
  always_comb begin
    rd1_data_s = '0;
    rd2_data_s = '0;
    rd1_data_s = read_port(!rst_n, bus.rd1_enable, bus.rd1_address,
                           bus.wr_enable, bus.wr_address, bus.wr_data,
                           regs_r[bus.rd1_address]);
    rd2_data_s = read_port(!rst_n, bus.rd2_enable, bus.rd2_address,
                           bus.wr_enable, bus.wr_address, bus.wr_data,
                           regs_r[bus.rd2_address]);
  end

  assign bus.rd1_data = rd1_data_s;
  assign bus.rd2_data = rd2_data_s;

endmodule : regfile

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, multi-cycle reset
// sequences and randomized traffic against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];

  regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference storage: a write lands on the clock edge unless it targets r0
  // or reset is low; reset wipes everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'h0;
    end else if (bus.wr_enable && bus.wr_address != 5'd0) begin
      model[bus.wr_address] <= bus.wr_data;
    end
  end

  function automatic logic [31:0] ref_read(input logic en, input logic [4:0] a);
    if (!rst_n) return 32'h0;
    if (!en) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (bus.wr_enable && bus.wr_address == a) return bus.wr_data;
    return model[a];
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1e, input logic [4:0] r1a,
                       input logic r2e, input logic [4:0] r2a);
    bus.wr_enable   = we;
    bus.wr_address  = wa;
    bus.wr_data     = wd;
    bus.rd1_enable  = r1e;
    bus.rd1_address = r1a;
    bus.rd2_enable  = r2e;
    bus.rd2_address = r2a;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        r1e;
    logic [4:0]  r1a;
    logic        r2e;
    logic [4:0]  r2a;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 1'b0, 5'd5, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd5, 32'h0,        1'b1, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd5, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b1, 5'd0, 32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd7, 1'b1, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 5'd7, 32'hFFFFFFFF, 1'b1, 5'd7, 1'b1, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 5'd3, 32'h00000001, 1'b1, 5'd5, 1'b0, 5'd3, 32'hDEADBEEF, 32'h0};
    vecs[7] = '{1'b0, 5'd3, 32'h00000055, 1'b1, 5'd3, 1'b1, 5'd3, 32'h00000001, 32'h00000001};
    vecs[8] = '{1'b1, 5'd3, 32'hAAAA0000, 1'b0, 5'd3, 1'b1, 5'd3, 32'h0,        32'hAAAA0000};
    vecs[9] = '{1'b0, 5'd3, 32'h0,        1'b1, 5'd3, 1'b1, 5'd7, 32'hAAAA0000, 32'hCAFEF00D};

    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Power-on reset; outputs forced to zero even with a bypass-able write.
    #2 rst_n = 1'b0;
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    check("reset_rd1", bus.rd1_data, 32'h0);
    check("reset_rd2", bus.rd2_data, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    rst_n = 1'b1;

    // Every register reads zero after reset on both ports.
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(31 - a));
      #1;
      check($sformatf("post_reset_rd1_r%0d", a), bus.rd1_data, 32'h0);
      check($sformatf("post_reset_rd2_r%0d", 31 - a), bus.rd2_data, 32'h0);
    end

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1e, vecs[i].r1a,
            vecs[i].r2e, vecs[i].r2a);
      #1;
      check($sformatf("vec%0d_rd1", i), bus.rd1_data, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), bus.rd2_data, vecs[i].e2);
    end

    // Fill r1..r31, then pulse reset for 3 ns between clock edges.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      drive(1'b1, 5'(a), 32'hA5000000 + 32'(a), 1'b0, 5'd0, 1'b0, 5'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd31);
    #1;
    check("filled_r9", bus.rd1_data, 32'hA5000009);
    check("filled_r31", bus.rd2_data, 32'hA500001F);
    #0.5 rst_n = 1'b0;
    #1;
    check("pulse_low_rd1", bus.rd1_data, 32'h0);
    check("pulse_low_rd2", bus.rd2_data, 32'h0);
    #2 rst_n = 1'b1;
    #0.2;
    check("pulse_release_rd1", bus.rd1_data, 32'h0);
    check("pulse_release_rd2", bus.rd2_data, 32'h0);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(a));
      #1;
      check($sformatf("cleared_rd1_r%0d", a), bus.rd1_data, 32'h0);
      check($sformatf("cleared_rd2_r%0d", a), bus.rd2_data, 32'h0);
    end

    // Reset held across the edge of a write: the write is lost, and the
    // first write after release takes effect on the next edge.
    @(negedge clk);
    drive(1'b1, 5'd12, 32'h00000077, 1'b1, 5'd12, 1'b0, 5'd0);
    #1 rst_n = 1'b0;
    #1;
    check("midwrite_reset_rd1", bus.rd1_data, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd0);
    #1 rst_n = 1'b1;
    #1;
    check("midwrite_lost", bus.rd1_data, 32'h0);
    @(negedge clk);
    drive(1'b1, 5'd12, 32'h00000088, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd12);
    #1;
    check("first_write_after_reset_rd1", bus.rd1_data, 32'h00000088);
    check("first_write_after_reset_rd2", bus.rd2_data, 32'h00000088);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic        we, r1e, r2e;
      logic [4:0]  wa, r1a, r2a;
      logic [31:0] wd;
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      r1e = ($urandom_range(0, 7) != 0);
      r2e = ($urandom_range(0, 7) != 0);
      r1a = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      r2a = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      @(negedge clk);
      drive(we, wa, wd, r1e, r1a, r2e, r2a);
      #1;
      check($sformatf("rand%0d_rd1", n), bus.rd1_data, ref_read(r1e, r1a));
      check($sformatf("rand%0d_rd2", n), bus.rd2_data, ref_read(r2e, r2a));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile
